// File: rtl/mac_frame_gen.sv
// Ethernet MAC frame generator for an MII (DW=4) or GMII (DW=8) transmit bus:
// preamble/SFD, 14-byte header, incrementing or PRBS8 payload, zero pad, CRC-32 FCS, IFG.
module mac_frame_gen #(
  parameter int DW      = 4,
  parameter int PRE_LEN = 8,
  parameter int IFG     = 12
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [47:0]   da,
  input  logic [47:0]   sa,
  input  logic [15:0]   len_type,
  input  logic [10:0]   length,
  input  logic          pat_mode,
  input  logic          crc_err,
  output logic          tx_dv,
  output logic [DW-1:0] tx_d,
  output logic          busy,
  output logic          done,
  output logic [15:0]   frame_cnt,
  output logic [2:0]    dbg_state
);

  localparam int NB = 8 / DW;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0] BEAT_LAST  = BW'(NB - 1);
  localparam logic [11:0]   PRE_LAST   = 12'(PRE_LEN - 2);
  localparam logic [11:0]   GAP_LAST   = 12'(IFG - 1);
  localparam logic [11:0]   HDR_LAST   = 12'd13;
  localparam logic [11:0]   PAD_LAST   = 12'd59;
  localparam logic [11:0]   FCS_LAST   = 12'd3;
  localparam logic [10:0]   MIN_LEN    = 11'd60;
  localparam logic [10:0]   MAX_LEN    = 11'd1514;
  localparam logic [10:0]   HDR_LEN    = 11'd14;
  localparam logic [31:0]   CRC_POLY_R = 32'hEDB8_8320;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_SFD  = 3'd2,
    S_HDR  = 3'd3,
    S_PAY  = 3'd4,
    S_PAD  = 3'd5,
    S_FCS  = 3'd6,
    S_GAP  = 3'd7
  } state_t;

  state_t         state, state_n;
  logic [11:0]    cnt;
  logic [BW-1:0]  beat;
  logic [111:0]   hdr_r;
  logic [10:0]    len_r;
  logic           pat_r;
  logic           err_r;
  logic [31:0]    crc;
  logic [7:0]     lfsr;
  logic [15:0]    frame_cnt_r;
  logic           done_r;

  logic           beat_last;
  logic           cnt_clr;
  logic           accept;
  logic           frame_end;
  logic           data_byte;
  logic [7:0]     cur_byte;
  logic [3:0]     hdr_idx;
  logic [31:0]    fcs_word;
  logic [11:0]    pay_last;
  logic [10:0]    len_clamp;

  // Reflected CRC-32, one byte at a time, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY_R) : (r >> 1);
    end
    return r;
  endfunction

  // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting toward the MSB.
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Only the upper clamp is stored; the lower clamp is realised by the PAD state.
  assign len_clamp = (length > MAX_LEN) ? MAX_LEN : length;
  assign pay_last  = {1'b0, len_r} - 12'd1;
  assign beat_last = (beat == BEAT_LAST);
  assign accept    = (state == S_IDLE) && start;
  assign data_byte = ((state == S_HDR) || (state == S_PAY) || (state == S_PAD)) && beat_last;
  assign frame_end = (state == S_GAP) && beat_last && (cnt == GAP_LAST);

  // Next state: cnt counts bytes within a state, but runs on across HDR/PAY/PAD
  // so it doubles as the frame byte index for payload and padding.
  always_comb begin
    state_n = state;
    cnt_clr = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        state_n = S_PRE;
        cnt_clr = 1'b1;
      end
      S_PRE: if (beat_last && (cnt == PRE_LAST)) begin
        state_n = S_SFD;
        cnt_clr = 1'b1;
      end
      S_SFD: if (beat_last) begin
        state_n = S_HDR;
        cnt_clr = 1'b1;
      end
      S_HDR: if (beat_last && (cnt == HDR_LAST)) begin
        state_n = (len_r > HDR_LEN) ? S_PAY : S_PAD;
      end
      S_PAY: if (beat_last && (cnt == pay_last)) begin
        if (len_r < MIN_LEN) begin
          state_n = S_PAD;
        end else begin
          state_n = S_FCS;
          cnt_clr = 1'b1;
        end
      end
      S_PAD: if (beat_last && (cnt == PAD_LAST)) begin
        state_n = S_FCS;
        cnt_clr = 1'b1;
      end
      S_FCS: if (beat_last && (cnt == FCS_LAST)) begin
        state_n = S_GAP;
        cnt_clr = 1'b1;
      end
      S_GAP: if (beat_last && (cnt == GAP_LAST)) begin
        state_n = S_IDLE;
        cnt_clr = 1'b1;
      end
      default: begin
        state_n = S_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // Byte currently on the wire.
  always_comb begin
    cur_byte = 8'h00;
    hdr_idx  = 4'd13 - cnt[3:0];
    fcs_word = err_r ? crc : ~crc;
    case (state)
      S_PRE:   cur_byte = 8'h55;
      S_SFD:   cur_byte = 8'hD5;
      S_HDR:   cur_byte = hdr_r[{hdr_idx, 3'b000} +: 8];
      S_PAY:   cur_byte = pat_r ? lfsr : (cnt[7:0] - 8'd14);
      S_PAD:   cur_byte = 8'h00;
      S_FCS:   cur_byte = fcs_word[{cnt[1:0], 3'b000} +: 8];
      default: cur_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      beat        <= '0;
      hdr_r       <= '0;
      len_r       <= '0;
      pat_r       <= 1'b0;
      err_r       <= 1'b0;
      crc         <= 32'hFFFF_FFFF;
      lfsr        <= 8'hFF;
      frame_cnt_r <= '0;
      done_r      <= 1'b0;
    end else begin
      state <= state_n;

      if (cnt_clr) begin
        cnt <= '0;
      end else if ((state != S_IDLE) && beat_last) begin
        cnt <= cnt + 12'd1;
      end

      if ((state == S_IDLE) || beat_last) begin
        beat <= '0;
      end else begin
        beat <= beat + BW'(1);
      end

      if (accept) begin
        hdr_r <= {da, sa, len_type};
        len_r <= len_clamp;
        pat_r <= pat_mode;
        err_r <= crc_err;
        crc   <= 32'hFFFF_FFFF;
        lfsr  <= 8'hFF;
      end else begin
        if (data_byte) begin
          crc <= crc32_byte(crc, cur_byte);
        end
        if ((state == S_PAY) && beat_last) begin
          lfsr <= lfsr_step(lfsr);
        end
      end

      done_r <= frame_end;
      if (frame_end) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
    end
  end

  // Outputs decode straight from registered state, so reset clears tx_dv asynchronously.
  always_comb begin
    tx_dv = (state == S_PRE) || (state == S_SFD) || (state == S_HDR) ||
            (state == S_PAY) || (state == S_PAD) || (state == S_FCS);
    tx_d  = tx_dv ? cur_byte[int'(beat) * DW +: DW] : '0;
  end

  assign busy      = (state != S_IDLE);
  assign done      = done_r;
  assign frame_cnt = frame_cnt_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_mac_frame_gen.sv
// Bench for mac_frame_gen: an MII (DW=4) and a GMII (DW=8) instance checked against
// a byte-level frame model (header, payload rules, pad, CRC-32, nibble ordering).
`timescale 1ns/1ps
module tb_mac_frame_gen;

  localparam int PRE  = 8;
  localparam int IFG4 = 12;
  localparam int IFG8 = 5;
  localparam int LIMIT = 4000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        start4, start8;
  logic [47:0] da, sa;
  logic [15:0] len_type;
  logic [10:0] length;
  logic        pat_mode, crc_err;

  logic        dv4, dv8, busy4, busy8, done4, done8;
  logic [3:0]  d4;
  logic [7:0]  d8;
  logic [15:0] fc4, fc8;
  logic [2:0]  st4, st8;

  mac_frame_gen #(.DW(4), .PRE_LEN(PRE), .IFG(IFG4)) dut4 (
    .clk(clk), .rstn(rstn), .start(start4), .da(da), .sa(sa), .len_type(len_type),
    .length(length), .pat_mode(pat_mode), .crc_err(crc_err), .tx_dv(dv4), .tx_d(d4),
    .busy(busy4), .done(done4), .frame_cnt(fc4), .dbg_state(st4));

  mac_frame_gen #(.DW(8), .PRE_LEN(PRE), .IFG(IFG8)) dut8 (
    .clk(clk), .rstn(rstn), .start(start8), .da(da), .sa(sa), .len_type(len_type),
    .length(length), .pat_mode(pat_mode), .crc_err(crc_err), .tx_dv(dv8), .tx_d(d8),
    .busy(busy8), .done(done8), .frame_cnt(fc8), .dbg_state(st8));

  bit          sel;
  logic        dv_m, busy_m, done_m;
  logic [7:0]  d_m;
  logic [15:0] fc_m;
  always_comb begin
    dv_m   = sel ? dv8   : dv4;
    busy_m = sel ? busy8 : busy4;
    done_m = sel ? done8 : done4;
    d_m    = sel ? d8    : {4'h0, d4};
    fc_m   = sel ? fc8   : fc4;
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_bytes[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] save_q[$];

  int          cap_dv, cap_gap, cap_bad;
  bit          cap_first, cap_timeout, cap_busy_done;
  logic [15:0] cap_fc;

  logic [47:0] f_da, f_sa;
  logic [15:0] f_lt;
  logic [10:0] f_len;
  bit          f_pat, f_err;

  // ---------------- reference model ----------------
  function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 32'hEDB88320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  function automatic int eff_len(input int len);
    if (len < 60) return 60;
    if (len > 1514) return 1514;
    return len;
  endfunction

  task automatic build_expected(input bit s);
    int le;
    logic [31:0] c, fcs;
    logic [7:0]  lf;
    logic [7:0]  data[$];
    le = eff_len(int'(f_len));
    for (int i = 0; i < 6; i++) data.push_back(8'(f_da >> (40 - 8 * i)));
    for (int i = 0; i < 6; i++) data.push_back(8'(f_sa >> (40 - 8 * i)));
    data.push_back(f_lt[15:8]);
    data.push_back(f_lt[7:0]);
    lf = 8'hFF;
    for (int i = 14; i < le; i++) begin
      if (i < int'(f_len)) begin
        if (f_pat) begin
          data.push_back(lf);
          lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
        end else begin
          data.push_back(8'((i - 14) % 256));
        end
      end else begin
        data.push_back(8'h00);
      end
    end
    c = 32'hFFFFFFFF;
    foreach (data[i]) c = crc_bits(c, data[i]);
    fcs = f_err ? c : ~c;
    exp_bytes.delete();
    for (int i = 0; i < PRE - 1; i++) exp_bytes.push_back(8'h55);
    exp_bytes.push_back(8'hD5);
    foreach (data[i]) exp_bytes.push_back(data[i]);
    for (int i = 0; i < 4; i++) exp_bytes.push_back(8'(fcs >> (8 * i)));
    exp_q.delete();
    foreach (exp_bytes[i]) begin
      if (s) exp_q.push_back(exp_bytes[i]);
      else begin
        exp_q.push_back({4'h0, exp_bytes[i][3:0]});
        exp_q.push_back({4'h0, exp_bytes[i][7:4]});
      end
    end
  endtask

  function automatic int first_diff();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic rand_fields();
    f_da  = 48'({$urandom(), $urandom()});
    f_sa  = 48'({$urandom(), $urandom()});
    f_lt  = 16'($urandom());
    f_len = 11'($urandom_range(0, 2047));
    f_pat = 1'($urandom_range(0, 1));
    f_err = 1'($urandom_range(0, 1));
  endtask

  // ---------------- driver / monitor ----------------
  // Called at a negedge; returns at the negedge where done is seen (or at the cycle limit).
  task automatic run_frame(input bit s, input int disturb_at);
    int cyc;
    sel = s;
    got_q.delete();
    cap_dv = 0; cap_gap = 0; cap_bad = 0; cap_timeout = 0;
    da = f_da; sa = f_sa; len_type = f_lt; length = f_len; pat_mode = f_pat; crc_err = f_err;
    if (s) start8 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; start8 = 1'b0;
    cap_first = dv_m;
    cyc = 0;
    while (!done_m && cyc < LIMIT) begin
      if (dv_m) begin
        if (cap_gap != 0) cap_bad++;
        got_q.push_back(d_m);
        cap_dv++;
      end else begin
        cap_gap++;
        if (d_m != 8'h00 || !busy_m) cap_bad++;
      end
      if (dv_m && cap_dv == disturb_at) begin
        da = 48'({$urandom(), $urandom()});
        sa = 48'({$urandom(), $urandom()});
        len_type = 16'($urandom());
        length = 11'($urandom());
        pat_mode = ~f_pat;
        crc_err = ~f_err;
        if (s) start8 = 1'b1; else start4 = 1'b1;
      end else begin
        start4 = 1'b0; start8 = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start4 = 1'b0; start8 = 1'b0;
    cap_timeout = !done_m;
    cap_busy_done = busy_m;
    cap_fc = fc_m;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_checks++; if (dv4 !== 1'b0 || d4 !== 4'h0) begin n_fail++; $display("FAIL reset_tx4 dv=%b d=%h exp dv=0 d=0", dv4, d4); end
    n_checks++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy4 busy=%b done=%b exp 0/0", busy4, done4); end
    n_checks++; if (fc4 !== 16'h0 || st4 !== 3'd0) begin n_fail++; $display("FAIL reset_cnt4 fc=%0d st=%0d exp 0/0", fc4, st4); end
    n_checks++; if (dv8 !== 1'b0 || d8 !== 8'h0 || busy8 !== 1'b0 || fc8 !== 16'h0) begin
      n_fail++; $display("FAIL reset_dut8 dv=%b d=%h busy=%b fc=%0d exp all 0", dv8, d8, busy8, fc8); end
  endtask

  task automatic test_known_frame();
    logic [15:0] fc0;
    logic [31:0] c, rev;
    int fd, ok_pre;
    fc0 = fc4;
    f_da = 48'hf0f1f2f3f4f5; f_sa = 48'he0e1e2e3e4e5; f_lt = 16'h0800;
    f_len = 11'd100; f_pat = 1'b0; f_err = 1'b0;
    build_expected(1'b0);
    run_frame(1'b0, -1);
    n_checks++; if (cap_timeout || !cap_first) begin n_fail++; $display("FAIL known_start timeout=%b first_dv=%b exp 0/1", cap_timeout, cap_first); end
    n_checks++; if (cap_dv != (PRE + 100 + 4) * 2) begin n_fail++; $display("FAIL known_dv_len got=%0d exp=%0d", cap_dv, (PRE + 100 + 4) * 2); end
    ok_pre = (got_q.size() >= 16) ? 1 : 0;
    for (int i = 0; i < 15 && ok_pre == 1; i++) if (got_q[i] !== 8'h05) ok_pre = 0;
    if (ok_pre == 1 && got_q[15] !== 8'h0D) ok_pre = 0;
    n_checks++; if (ok_pre != 1) begin n_fail++; $display("FAIL known_preamble got_ok=%0d exp=1", ok_pre); end
    n_checks++; if (got_q.size() < 20 || {got_q[16][3:0], got_q[17][3:0], got_q[18][3:0], got_q[19][3:0]} !== 16'h0F1F) begin
      n_fail++; $display("FAIL known_first_nibbles size=%0d exp 0,f,1,f", got_q.size()); end
    fd = first_diff();
    n_checks++; if (fd != -1) begin n_fail++; $display("FAIL known_frame first diff at beat %0d (got %0d beats exp %0d)", fd, got_q.size(), exp_q.size()); end
    c = 32'hFFFFFFFF;
    for (int j = PRE; 2 * j + 1 < got_q.size(); j++) c = crc_bits(c, {got_q[2*j+1][3:0], got_q[2*j][3:0]});
    rev = {<<{c}};
    n_checks++; if (rev !== 32'hC704DD7B) begin n_fail++; $display("FAIL known_residue got=%h exp=c704dd7b", rev); end
    n_checks++; if (cap_gap != IFG4 * 2) begin n_fail++; $display("FAIL known_gap got=%0d exp=%0d", cap_gap, IFG4 * 2); end
    n_checks++; if (cap_fc !== fc0 + 16'd1 || cap_busy_done !== 1'b0 || cap_bad != 0) begin
      n_fail++; $display("FAIL known_end fc=%0d exp=%0d busy=%b bad=%0d", cap_fc, fc0 + 16'd1, cap_busy_done, cap_bad); end
    save_q = got_q;
    @(negedge clk);
    n_checks++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL known_done_pulse done=%b exp=0", done4); end
  endtask

  task automatic test_crc_err();
    int bad_pay, bad_fcs, n;
    f_err = 1'b1;
    build_expected(1'b0);
    run_frame(1'b0, -1);
    n_checks++; if (first_diff() != -1) begin n_fail++; $display("FAIL crcerr_frame first diff at beat %0d", first_diff()); end
    bad_pay = 0; bad_fcs = 0;
    n = got_q.size();
    if (n != save_q.size() || n < 8) bad_pay = 1;
    else begin
      for (int i = 0; i < n - 8; i++) if (got_q[i] !== save_q[i]) bad_pay++;
      for (int i = n - 8; i < n; i++) if (got_q[i][3:0] !== ~save_q[i][3:0]) bad_fcs++;
    end
    n_checks++; if (bad_pay != 0) begin n_fail++; $display("FAIL crcerr_payload differing_beats=%0d exp=0", bad_pay); end
    n_checks++; if (bad_fcs != 0) begin n_fail++; $display("FAIL crcerr_fcs non_complemented=%0d exp=0", bad_fcs); end
  endtask

  task automatic test_pad();
    int bad;
    rand_fields();
    f_len = 11'd20; f_pat = 1'b0; f_err = 1'b0;
    build_expected(1'b1);
    run_frame(1'b1, -1);
    n_checks++; if (cap_dv != PRE + 60 + 4) begin n_fail++; $display("FAIL pad_dv_len got=%0d exp=%0d", cap_dv, PRE + 60 + 4); end
    bad = (got_q.size() >= PRE + 60) ? 0 : 1;
    for (int k = 0; k < 6 && bad == 0; k++) if (got_q[PRE + 14 + k] !== 8'(k)) bad++;
    for (int k = 20; k < 60 && bad == 0; k++) if (got_q[PRE + k] !== 8'h00) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL pad_bytes bad=%0d exp=0", bad); end
    n_checks++; if (first_diff() != -1) begin n_fail++; $display("FAIL pad_frame first diff at beat %0d", first_diff()); end
    n_checks++; if (cap_gap != IFG8) begin n_fail++; $display("FAIL pad_gap got=%0d exp=%0d", cap_gap, IFG8); end
  endtask

  task automatic test_truncate_ignore_start();
    logic [15:0] fc0;
    int extra_dv;
    fc0 = fc8;
    rand_fields();
    f_len = 11'd2000;
    build_expected(1'b1);
    run_frame(1'b1, 300);
    n_checks++; if (cap_dv != PRE + 1514 + 4) begin n_fail++; $display("FAIL trunc_dv_len got=%0d exp=%0d", cap_dv, PRE + 1514 + 4); end
    n_checks++; if (first_diff() != -1) begin n_fail++; $display("FAIL trunc_frame first diff at beat %0d", first_diff()); end
    extra_dv = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dv8) extra_dv++;
    end
    n_checks++; if (extra_dv != 0 || fc8 !== fc0 + 16'd1) begin
      n_fail++; $display("FAIL trunc_ignore_start extra_dv=%0d fc=%0d exp 0/%0d", extra_dv, fc8, fc0 + 16'd1); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] fc0;
    int gap1;
    fc0 = fc4;
    rand_fields();
    f_len = 11'($urandom_range(60, 200)); f_pat = 1'b1; f_err = 1'b0;
    build_expected(1'b0);
    run_frame(1'b0, -1);
    gap1 = cap_gap;
    save_q = got_q;
    n_checks++; if (first_diff() != -1) begin n_fail++; $display("FAIL b2b_frame1 first diff at beat %0d", first_diff()); end
    n_checks++; if (got_q.size() < 48 || {got_q[44][3:0], got_q[45][3:0], got_q[46][3:0], got_q[47][3:0]} !== 16'hFFEF) begin
      n_fail++; $display("FAIL b2b_lfsr_seed size=%0d exp nibbles f,f,e,f", got_q.size()); end
    run_frame(1'b0, -1);
    n_checks++; if (!cap_first) begin n_fail++; $display("FAIL b2b_accept first_dv=%b exp=1", cap_first); end
    n_checks++; if (got_q != save_q) begin n_fail++; $display("FAIL b2b_identical beats=%0d/%0d exp equal payloads", got_q.size(), save_q.size()); end
    n_checks++; if (gap1 != IFG4 * 2 || cap_gap != IFG4 * 2) begin n_fail++; $display("FAIL b2b_gap got=%0d,%0d exp=%0d", gap1, cap_gap, IFG4 * 2); end
    n_checks++; if (cap_fc !== fc0 + 16'd2) begin n_fail++; $display("FAIL b2b_count got=%0d exp=%0d", cap_fc, fc0 + 16'd2); end
  endtask

  task automatic test_random();
    bit s;
    for (int n = 0; n < 6; n++) begin
      s = 1'($urandom_range(0, 1));
      rand_fields();
      build_expected(s);
      run_frame(s, -1);
      n_checks++; if (first_diff() != -1 || cap_timeout) begin
        n_fail++; $display("FAIL rand_frame%0d dw=%0d len=%0d diff_at=%0d timeout=%b", n, s ? 8 : 4, f_len, first_diff(), cap_timeout); end
      n_checks++; if (cap_gap != (s ? IFG8 : IFG4 * 2) || cap_bad != 0) begin
        n_fail++; $display("FAIL rand_gap%0d got=%0d exp=%0d bad=%0d", n, cap_gap, s ? IFG8 : IFG4 * 2, cap_bad); end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit was_dv;
    rand_fields();
    f_len = 11'd100; f_pat = 1'b1;
    sel = 1'b0;
    da = f_da; sa = f_sa; len_type = f_lt; length = f_len; pat_mode = f_pat; crc_err = f_err;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (104) @(negedge clk);
    was_dv = dv4;
    #2 rstn = 1'b0;
    #1;
    n_checks++; if (!was_dv || dv4 !== 1'b0 || d4 !== 4'h0) begin
      n_fail++; $display("FAIL midrst_dv before=%b dv=%b d=%h exp 1/0/0", was_dv, dv4, d4); end
    n_checks++; if (busy4 !== 1'b0 || fc4 !== 16'h0 || st4 !== 3'd0) begin
      n_fail++; $display("FAIL midrst_state busy=%b fc=%0d st=%0d exp 0/0/0", busy4, fc4, st4); end
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    build_expected(1'b0);
    run_frame(1'b0, -1);
    n_checks++; if (first_diff() != -1 || cap_timeout) begin
      n_fail++; $display("FAIL midrst_frame diff_at=%0d timeout=%b", first_diff(), cap_timeout); end
    n_checks++; if (cap_fc !== 16'd1) begin n_fail++; $display("FAIL midrst_count got=%0d exp=1", cap_fc); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    start4 = 1'b0; start8 = 1'b0; sel = 1'b0;
    da = '0; sa = '0; len_type = '0; length = '0; pat_mode = 1'b0; crc_err = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    test_known_frame();
    test_crc_err();
    test_pad();
    test_truncate_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
